// File: rtl/booth_r8_pkg.sv
// booth_r8_pkg: shared types and helpers for the radix-8 Booth sequential multiplier
package booth_r8_pkg;
  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;
  typedef enum logic [4:0] {
    SEL_ZERO = 5'b00001,
    SEL_P1   = 5'b00010,
    SEL_P2   = 5'b00100,
    SEL_P3   = 5'b01000,
    SEL_P4   = 5'b10000
  } booth_onehot_t;
  typedef struct packed {
    booth_onehot_t sel;
    logic          neg;
  } booth_sel_t;
  function automatic int booth_nd(input int w);
    return (w + 3) / 3;
  endfunction
  // win = {b2, b1, b0, bm1}; digit = -4*b2 + 2*b1 + b0 + bm1
  function automatic booth_sel_t booth_decode(input logic [3:0] win);
    logic [2:0] s;
    logic [2:0] m;
    booth_sel_t r;
    s = {1'b0, win[2], 1'b0} + {2'b00, win[1]} + {2'b00, win[0]};
    m = win[3] ? 3'd4 - s : s;
    r.neg = win[3] && s != 3'd4;
    r.sel = m == 3'd1 ? SEL_P1 : m == 3'd2 ? SEL_P2 : m == 3'd3 ? SEL_P3 : m == 3'd4 ? SEL_P4 : SEL_ZERO;
    return r;
  endfunction
endpackage

// File: rtl/booth_r8_digit_sel.sv
// booth_r8_digit_sel: maps one Booth window onto a signed partial product d*A
module booth_r8_digit_sel
  import booth_r8_pkg::*;
#(
  parameter int MANT_W = 11
) (
  input  logic [3:0]            win,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W+1:0]     a3,
  output logic signed [2*MANT_W+1:0] pp
);
  localparam int PW = 2 * MANT_W + 2;
  booth_sel_t s;
  logic [PW-1:0] m;
  always_comb begin
    s  = booth_decode(win);
    m  = s.sel == SEL_P1 ? PW'(a) :
         s.sel == SEL_P2 ? PW'({a, 1'b0}) :
         s.sel == SEL_P3 ? PW'(a3) :
         s.sel == SEL_P4 ? PW'({a, 2'b00}) : '0;
    pp = s.neg ? $signed(~m + PW'(1)) : $signed(m);
  end
endmodule

// File: rtl/booth_r8_seq_mul.sv
// booth_r8_seq_mul: sequential radix-8 Booth mantissa multiplier, one digit per cycle MSB-first
module booth_r8_seq_mul
  import booth_r8_pkg::*;
#(
  parameter int MANT_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     mantissa_a,
  input  logic [MANT_W-1:0]     mantissa_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   product,
  output logic                  busy
);
  localparam int ND = booth_nd(MANT_W);
  localparam int PW = 2 * MANT_W + 2;
  localparam int BW = 3 * ND + 1;
  localparam int CW = $clog2(ND + 1);
  state_t state, state_nxt;
  logic [MANT_W-1:0] a_r;
  logic [MANT_W+1:0] a3;
  logic [BW-1:0] bx;
  logic [CW-1:0] cnt;
  logic fin;
  logic signed [PW-1:0] acc, pp;
  logic [3:0] win;
  // bx bit 0 holds the implicit Bx[-1], so digit i sits at bx[3i+3:3i]
  assign win = 4'(bx >> (3 * cnt));
  booth_r8_digit_sel #(.MANT_W(MANT_W)) u_sel (
    .win (win),
    .a   (a_r),
    .a3  (a3),
    .pp  (pp)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    state_nxt = state == IDLE ? (in_valid ? PRE : IDLE) :
                state == PRE  ? ITER :
                state == ITER ? (fin ? DONE : ITER) :
                (out_ready ? IDLE : DONE);
  end
  // fin marks the extra ITER cycle that moves the finished accumulator into product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      a3      <= '0;
      bx      <= '0;
      cnt     <= '0;
      fin     <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r <= mantissa_a;
      bx  <= BW'({mantissa_b, 1'b0});
    end else if (state == PRE) begin
      a3  <= {2'b00, a_r} + {1'b0, a_r, 1'b0};
      acc <= '0;
      cnt <= CW'(ND - 1);
      fin <= 1'b0;
    end else if (state == ITER) begin
      if (fin) product <= acc[2*MANT_W-1:0];
      else begin
        acc <= (acc <<< 3) + pp;
        cnt <= cnt - CW'(1);
        fin <= cnt == '0;
      end
    end
  end
endmodule

// File: doc/booth_r8_seq_mul.md
Name: booth_r8_seq_mul

Overview:
- Sequential radix-8 Booth mantissa multiplier: the consumer side of the Booth multiple-generation path.
- Accepts one unsigned A/B mantissa pair over a valid/ready handshake and precomputes the multiples of A (0, ±A, ±2A, ±3A, ±4A).
- Recodes B into radix-8 Booth digits, selects one partial product per cycle and accumulates it MSB-digit-first.
- Returns the exact 2*MANT_W-bit product over a valid/ready handshake; feeds the FP16/BF16 FMA datapath.

Parameters:
- MANT_W, 11, mantissa width including hidden bit (11 = FP16, 8 = BF16/INT8 path).
- ND, (MANT_W+1+2)/3 (integer division, i.e. ceil((MANT_W+1)/3)), number of Booth digits; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands (IDLE only).
- mantissa_a  in  MANT_W  unsigned multiplicand.
- mantissa_b  in  MANT_W  unsigned multiplier (Booth-recoded).
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  2*MANT_W  unsigned A*B.
- busy  out  1  high in PRE, ITER or DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1 after reset deasserts; out_valid=0; busy=0.
  - product=0; accumulator, counter and operand registers=0.
  - Applies immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE -> PRE -> ITER (ND cycles) -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register A, and register B extended to Bx = {zero-pad to 3*ND bits, B, 1'b0}, where bit -1 = 0.
  - Go to PRE.
- PRE:
  - Register 3A = A + 2A, width MANT_W+2.
  - acc=0; digit counter cnt=ND-1; go to ITER.
- ITER:
  - Digit i=cnt uses Bx bits [3i+2:3i] and bit 3i-1.
  - d = -4*b2 + 2*b1 + b0 + bm1, in {-4..+4}.
  - pp = d*A, sign-extended; acc <= (acc <<< 3) + pp.
  - acc is signed, 2*MANT_W+2 bits.
  - cnt decrements each cycle. After the cnt=0 update, product <= acc[2*MANT_W-1:0] and state goes to DONE.
  - The top digit is always >= 0 because padding guarantees Bx[3*ND-1]=0. The final acc is never negative.
- DONE:
  - out_valid=1; product held stable.
  - in_valid is ignored (in_ready=0).
  - On out_ready=1, go to IDLE with out_valid=0 the next cycle. product keeps its value until the next DONE entry.
- Latency and throughput (out_ready held high):
  - Accept at edge t gives out_valid=1 in cycle t+ND+2.
  - Next accept is possible at cycle t+ND+3, i.e. one op per ND+3 cycles (7 for MANT_W=11).
- Backpressure: out_valid and product stay stable indefinitely while out_ready=0.
- No early-out on zero operands; latency is fixed.
- in_valid asserted during reset is not captured.

Decomposition:
- Package booth_r8_pkg holds:
  - state enum {IDLE, PRE, ITER, DONE}.
  - booth_sel_t one-hot select {ZERO, P1, P2, P3, P4} plus a neg flag.
  - function booth_nd(w) returning ceil((w+1)/3).
- Sub-module booth_r8_digit_sel (combinational): triplet+bm1 and the registered multiples in; signed partial product out. Negation is ~x+1, applied inside.
- The top module holds the FSM, counter, operand/3A registers and accumulator.

Test Plan:
- A=0x7FF, B=0x7FF, out_ready=1 -> product=0x3FF001; out_valid first high exactly 6 cycles after accept; in_ready returns 1 one cycle later.
- A=3, B=5 -> digits (MSB..LSB) 0,0,+1,-3; product=0x00000F. Covers a negative digit and bm1 carry.
- A=0, B=0x7FF and A=0x400, B=0 -> product=0 with the same fixed latency. A=0x400, B=0x7FF -> 0x1FFC00.
- Backpressure: A=0x123, B=0x456, out_ready=0 for 5 cycles, in_valid held with A=1, B=1 -> product=0x04EDC2 stable throughout, second pair not captured until IDLE, then product=1.
- Assert rst for 1 cycle during the second ITER cycle -> out_valid=0, product=0, busy=0 immediately; in_ready=1 after release; next op (A=2, B=7) -> 14.
- Random 10k pairs at MANT_W=11 and MANT_W=8 (ND=3, latency 5) with random out_ready -> product == A*B, no duplicated or dropped results.
